// File: rtl/tt_vpu_ovi_store_sched_if.sv
// Signal bundle between the vector store scheduler and its surroundings.
// The slave side is the scheduler; the master side drives requests, register data and OVI returns.
interface tt_vpu_ovi_store_sched_if #(
  parameter int VLEN = 256
);
  logic                st_start;
  logic [3:0]          st_nregs;
  logic                st_abort;
  logic                vs_valid;
  logic [VLEN-1:0]     vs_data;
  logic                vs_ready;
  logic                store_valid;
  logic [2*VLEN-1:0]   store_data;
  logic                store_credit;
  logic                memop_sync_start;
  logic                memop_sync_end;
  logic                st_done;
  logic                busy;

  modport master (
    output st_start, st_nregs, st_abort, vs_valid, vs_data, store_credit, memop_sync_end,
    input  vs_ready, store_valid, store_data, memop_sync_start, st_done, busy
  );

  modport slave (
    input  st_start, st_nregs, st_abort, vs_valid, vs_data, store_credit, memop_sync_end,
    output vs_ready, store_valid, store_data, memop_sync_start, st_done, busy
  );
endinterface

// File: rtl/tt_vpu_ovi_store_sched.sv
// Vector store scheduler: buffers vs3 registers and emits credit-limited
// double-width OVI store beats, framed by memop sync start/end.
module tt_vpu_ovi_store_sched #(
  parameter int VLEN          = 256,
  parameter int STORE_CREDITS = 32,
  parameter int BUF_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  tt_vpu_ovi_store_sched_if.slave   bus
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int CW = $clog2(STORE_CREDITS) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, SYNC = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [VLEN-1:0]   mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [OW-1:0]     occ_reg;
  logic [3:0]        nregs_reg, recv_reg, sent_reg, sent_after;
  logic [CW-1:0]     credits_reg;
  logic              store_valid_reg, sync_start_reg, st_done_reg;
  logic [2*VLEN-1:0] store_data_reg;
  logic              vs_ready_c, accept, head_last, pop_one, pop_two, pop, start_ok;
  logic [1:0]        pop_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    vs_ready_c = reset_n && (state_reg == XFER) && (occ_reg < OW'(BUF_DEPTH))
                 && (recv_reg < nregs_reg);
    accept     = bus.vs_valid && vs_ready_c;
    head_last  = ((sent_reg + 4'd1) == nregs_reg);
    // An abort kills the pop so no new beat is launched into the flushed memop.
    pop_two    = (state_reg == XFER) && !bus.st_abort && (credits_reg != '0)
                 && (occ_reg >= OW'(2));
    pop_one    = (state_reg == XFER) && !bus.st_abort && (credits_reg != '0)
                 && (occ_reg == OW'(1)) && head_last;
    pop        = pop_one || pop_two;
    pop_cnt    = pop_two ? 2'd2 : (pop_one ? 2'd1 : 2'd0);
    sent_after = sent_reg + {2'b00, pop_cnt};
    start_ok   = (state_reg == IDLE) && bus.st_start && !bus.st_abort;
    rd_ptr_inc = ptr_inc(rd_ptr_reg);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = (bus.st_nregs == 4'd0) ? SYNC : XFER;
      XFER:    if (pop && (sent_after == nregs_reg)) state_next = SYNC;
      SYNC:    if (bus.memop_sync_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.st_abort) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_reg] <= bus.vs_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      occ_reg         <= '0;
      nregs_reg       <= '0;
      recv_reg        <= '0;
      sent_reg        <= '0;
      credits_reg     <= CW'(STORE_CREDITS);
      store_valid_reg <= 1'b0;
      store_data_reg  <= '0;
      sync_start_reg  <= 1'b0;
      st_done_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      store_valid_reg <= pop;
      sync_start_reg  <= start_ok;
      st_done_reg     <= (state_reg == SYNC) && bus.memop_sync_end && !bus.st_abort;
      if (pop)
        store_data_reg <= {pop_two ? mem[rd_ptr_inc] : {VLEN{1'b0}}, mem[rd_ptr_reg]};

      if (bus.st_abort) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        occ_reg    <= '0;
      end else begin
        if (accept) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop_two)      rd_ptr_reg <= ptr_inc(rd_ptr_inc);
        else if (pop_one) rd_ptr_reg <= rd_ptr_inc;
        occ_reg <= occ_reg + OW'(accept) - OW'(pop_cnt);
      end

      if (start_ok) begin
        nregs_reg <= bus.st_nregs;
        recv_reg  <= '0;
        sent_reg  <= '0;
      end else begin
        if (accept) recv_reg <= recv_reg + 4'd1;
        if (pop)    sent_reg <= sent_after;
      end

      // A return and a send in the same cycle cancel; returns saturate at the full pool.
      case ({bus.store_credit, pop})
        2'b10:   if (credits_reg != CW'(STORE_CREDITS)) credits_reg <= credits_reg + CW'(1);
        2'b01:   credits_reg <= credits_reg - CW'(1);
        default: credits_reg <= credits_reg;
      endcase
    end
  end

  assign bus.vs_ready         = vs_ready_c;
  assign bus.store_valid      = store_valid_reg;
  assign bus.store_data       = store_data_reg;
  assign bus.memop_sync_start = sync_start_reg;
  assign bus.st_done          = st_done_reg;
  assign bus.busy             = (state_reg != IDLE);
endmodule

// File: tb/tb_tt_vpu_ovi_store_sched.sv
// Bench for the vector store scheduler: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_tt_vpu_ovi_store_sched;
  localparam int VLEN = 256;
  localparam int SC   = 32;
  localparam int BD   = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tt_vpu_ovi_store_sched_if #(.VLEN(VLEN)) bus();

  tt_vpu_ovi_store_sched #(.VLEN(VLEN), .STORE_CREDITS(SC), .BUF_DEPTH(BD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // stimulus to apply on the next cycle
  logic            d_rst, d_start, d_abort, d_valid, d_credit, d_end;
  logic [3:0]      d_nregs;
  logic [VLEN-1:0] d_data;

  // behavioural model: 0 idle, 1 transferring, 2 waiting for sync end
  int              m_phase, m_credits, m_nregs, m_recv, m_sent;
  logic [VLEN-1:0] m_q[$];
  logic            e_sv, e_mss, e_done;
  logic [2*VLEN-1:0] e_sd;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int cyc    = 0;

  task automatic check_val(input string tag, input logic [2*VLEN-1:0] got,
                           input logic [2*VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [VLEN-1:0] rand_word();
    logic [VLEN-1:0] w;
    for (int i = 0; i < VLEN / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic apply_inputs();
    reset_n            = d_rst;
    bus.st_start       = d_start;
    bus.st_nregs       = d_nregs;
    bus.st_abort       = d_abort;
    bus.vs_valid       = d_valid;
    bus.vs_data        = d_data;
    bus.store_credit   = d_credit;
    bus.memop_sync_end = d_end;
  endtask

  // Advance the model across one rising edge using the stimulus currently applied.
  task automatic model_step(output bit acc);
    int npop;
    acc = 1'b0;
    if (!d_rst) begin
      m_phase = 0; m_credits = SC; m_q.delete(); m_recv = 0; m_sent = 0; m_nregs = 0;
      e_sv = 1'b0; e_sd = '0; e_mss = 1'b0; e_done = 1'b0;
      return;
    end
    acc  = d_valid && (m_phase == 1) && (m_q.size() < BD) && (m_recv < m_nregs);
    npop = 0;
    if (m_phase == 1 && !d_abort && m_credits > 0) begin
      if (m_q.size() >= 2) npop = 2;
      else if (m_q.size() == 1 && m_sent + 1 == m_nregs) npop = 1;
    end
    e_sv = (npop != 0);
    if (npop == 2) e_sd = {m_q[1], m_q[0]};
    else if (npop == 1) e_sd = {{VLEN{1'b0}}, m_q[0]};
    e_mss  = (m_phase == 0) && d_start && !d_abort;
    e_done = (m_phase == 2) && d_end && !d_abort;
    m_credits = m_credits - ((npop != 0) ? 1 : 0) + (d_credit ? 1 : 0);
    if (m_credits > SC) m_credits = SC;
    for (int k = 0; k < npop; k++) void'(m_q.pop_front());
    m_sent += npop;
    if (acc) begin
      m_q.push_back(d_data);
      m_recv++;
    end
    case (m_phase)
      0: if (e_mss) begin
           m_nregs = d_nregs; m_recv = 0; m_sent = 0;
           m_phase = (d_nregs == 0) ? 2 : 1;
         end
      1: if (npop != 0 && m_sent == m_nregs) m_phase = 2;
      2: if (d_end) m_phase = 0;
      default: m_phase = 0;
    endcase
    if (d_abort) begin
      m_phase = 0;
      m_q.delete();
    end
  endtask

  task automatic cycle();
    bit acc;
    @(negedge clk);
    apply_inputs();
    #1;
    check_val("vs_ready", bus.vs_ready, d_rst && m_phase == 1 && m_q.size() < BD && m_recv < m_nregs);
    model_step(acc);
    @(posedge clk);
    #1;
    cyc++;
    check_val("store_valid", bus.store_valid, e_sv);
    check_val("store_data", bus.store_data, e_sd);
    check_val("memop_sync_start", bus.memop_sync_start, e_mss);
    check_val("st_done", bus.st_done, e_done);
    check_val("busy", bus.busy, m_phase != 0);
    if (bus.store_valid) beats++;
    if (bus.memop_sync_start) $display("cyc %0d memop start nregs=%0d", cyc, m_nregs);
    if (bus.st_done) $display("cyc %0d memop done", cyc);
    if (acc) d_data = rand_word();
    d_start = 1'b0; d_abort = 1'b0; d_end = 1'b0; d_credit = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int maxc, input string tag);
    for (int i = 0; i < maxc && m_phase != ph; i++) cycle();
    if (m_phase != ph) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for phase %0d", tag, ph);
    end
    check_val({tag, "_busy"}, bus.busy, ph != 0);
  endtask

  task automatic wait_recv(input int n, input int maxc, input string tag);
    for (int i = 0; i < maxc && m_recv < n; i++) cycle();
    if (m_recv < n) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for %0d accepts", tag, n);
    end
  endtask

  task automatic memop(input int n, input int exp_beats, input string tag);
    beats   = 0;
    d_valid = 1'b1;
    d_start = 1'b1;
    d_nregs = 4'(n);
    cycle();
    wait_phase(2, 60, tag);
    repeat (2) cycle();
    d_end = 1'b1;
    cycle();
    cycle();
    check_val({tag, "_beats"}, 32'(beats), 32'(exp_beats));
    $display("%s nregs=%0d beats=%0d", tag, n, beats);
  endtask

  initial begin
    d_rst = 1'b0; d_start = 1'b0; d_abort = 1'b0; d_valid = 1'b0;
    d_credit = 1'b0; d_end = 1'b0; d_nregs = '0; d_data = rand_word();
    m_phase = 0; m_credits = SC; m_nregs = 0; m_recv = 0; m_sent = 0;
    e_sv = 1'b0; e_sd = '0; e_mss = 1'b0; e_done = 1'b0;
    apply_inputs();

    repeat (3) cycle();
    d_rst = 1'b1;

    // 33 returns with nothing sent must leave the pool at its maximum
    repeat (33) begin
      d_credit = 1'b1;
      cycle();
    end

    memop(4, 2, "r042");
    memop(3, 2, "r043a");
    memop(0, 0, "r043b");
    // remaining 28 credits consumed by seven 8-register memops
    for (int i = 0; i < 7; i++) memop(8, 4, "drain");

    // no credits: buffer fills, nothing is sent until a single credit returns
    beats = 0; d_valid = 1'b1; d_start = 1'b1; d_nregs = 4'd8;
    cycle();
    repeat (20) cycle();
    check_val("r044_no_beats", 32'(beats), 32'd0);
    check_val("r044_full_ready", bus.vs_ready, 1'b0);
    d_credit = 1'b1;
    cycle();
    repeat (5) cycle();
    check_val("r044_one_beat", 32'(beats), 32'd1);
    d_abort = 1'b1;
    cycle();
    cycle();

    // reset while five entries are buffered
    d_start = 1'b1; d_nregs = 4'd8;
    cycle();
    wait_recv(5, 20, "r047_fill");
    d_rst = 1'b0;
    cycle();
    check_val("r047_busy", bus.busy, 1'b0);
    check_val("r047_sv", bus.store_valid, 1'b0);
    d_rst = 1'b1;
    memop(8, 4, "r047_credits");

    // abort after 3 of 6 registers, then a fresh 2-register memop
    d_start = 1'b1; d_nregs = 4'd6;
    cycle();
    wait_recv(3, 20, "r046_fill");
    d_abort = 1'b1;
    cycle();
    check_val("r046_busy", bus.busy, 1'b0);
    repeat (3) cycle();
    memop(2, 1, "r046_new");

    // credit returns coinciding with sends
    beats = 0; d_start = 1'b1; d_nregs = 4'd8;
    for (int i = 0; i < 20; i++) begin
      d_credit = 1'b1;
      cycle();
    end
    d_end = 1'b1;
    cycle();
    cycle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      d_valid  = ($urandom_range(3) != 0);
      d_data   = rand_word();
      d_credit = ($urandom_range(2) == 0);
      if ($urandom_range(3) == 0) begin
        d_start = 1'b1;
        d_nregs = 4'($urandom_range(8));
      end
      d_end   = (m_phase == 2) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      d_abort = ($urandom_range(79) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_vpu_ovi_store_sched.md
TT_VPU_OVI_STORE_SCHED -- requirements
Module: tt_vpu_ovi_store_sched

Interface
REQ-001 SHALL have parameter VLEN, 256, width in bits of one vector register beat from the vector register file.
REQ-002 SHALL have parameter STORE_CREDITS, 32, OVI store credits held after reset.
REQ-003 SHALL have parameter BUF_DEPTH, 8, number of VLEN entries in the store buffer.
REQ-004 SHALL have clk  input  1  clock; all logic is sampled on its rising edge.
REQ-005 SHALL have reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have st_start  input  1  one-cycle request to begin a vector store memop.
REQ-007 SHALL have st_nregs  input  4  number of VLEN registers in the memop (0..8), sampled with st_start.
REQ-008 SHALL have st_abort  input  1  kill of the current memop.
REQ-009 SHALL have vs_valid  input  1  vs3 register data valid.
REQ-010 SHALL have vs_data  input  VLEN  vs3 register data.
REQ-011 SHALL have vs_ready  output  1  scheduler accepts vs_data this cycle.
REQ-012 SHALL have store_valid  output  1  OVI store data beat valid.
REQ-013 SHALL have store_data  output  2*VLEN  OVI store data beat, little-endian.
REQ-014 SHALL have store_credit  input  1  one store credit returned by the CPU.
REQ-015 SHALL have memop_sync_start  output  1  OVI memop start pulse.
REQ-016 SHALL have memop_sync_end  input  1  OVI memop end from the CPU.
REQ-017 SHALL have st_done  output  1  one-cycle completion pulse for the memop.
REQ-018 SHALL have busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 SHALL implement the states IDLE, XFER, SYNC.
REQ-020 IDLE: on st_start, SHALL latch st_nregs, clear the received and sent counters, and go to XFER (nregs!=0) or SYNC (nregs==0).
REQ-021 SHALL assert memop_sync_start for exactly one cycle, in the cycle after st_start is accepted in IDLE.
REQ-022 SHALL ignore st_start outside IDLE.
REQ-023 vs_ready SHALL equal (state==XFER) && (occupancy<BUF_DEPTH) && (received<nregs); a register is accepted when vs_valid && vs_ready.
REQ-024 The buffer SHALL be a circular FIFO; read and write pointers wrap modulo BUF_DEPTH.
REQ-025 In XFER, a beat is eligible when credits>0 and either (a) occupancy>=2, or (b) occupancy==1 and the head entry is the last register of the memop.
REQ-026 An eligible beat SHALL be popped in the same cycle, and store_valid and store_data SHALL be registered in the following cycle, with store_valid high for one cycle per beat.
REQ-027 A two-entry beat: store_data[VLEN-1:0]=head and store_data[2*VLEN-1:VLEN]=head+1. A single-entry beat: the upper half SHALL be zero.
REQ-028 An accept and a pop in the same cycle SHALL both take effect, and occupancy SHALL change by the net amount.
REQ-029 XFER->SYNC SHALL occur in the cycle the final register of the memop is popped.
REQ-030 SYNC: on memop_sync_end, SHALL pulse st_done in the next cycle and return to IDLE.
REQ-031 memop_sync_end outside SYNC SHALL be ignored.
REQ-032 The credit counter SHALL be $clog2(STORE_CREDITS)+1 bits wide.
REQ-033 Credits SHALL decrement by 1 per beat sent and increment by 1 per store_credit.
REQ-034 Simultaneous send and store_credit SHALL leave the credit count unchanged.
REQ-035 Credits SHALL saturate at STORE_CREDITS and never go below 0.
REQ-036 Credits SHALL persist across memops and SHALL NOT be changed by st_abort.
REQ-037 st_abort in any state SHALL, in the next cycle, set the state to IDLE, flush the buffer (pointers and occupancy to 0), and suppress st_done.
REQ-038 A store_valid beat already registered when st_abort arrives SHALL still be presented.
REQ-039 st_abort SHALL take priority over st_start in the same cycle.

Reset
REQ-040 While reset_n is low at a clock edge, SHALL set state=IDLE, credits=STORE_CREDITS, pointers/occupancy/counters=0, and hold store_valid, store_data, memop_sync_start, st_done, busy and vs_ready at 0.
REQ-041 Reset mid-memop SHALL discard all buffered data with no further outputs.

Verification
REQ-042 nregs=4, vs_valid held high, credits=32 -> one memop_sync_start pulse, two beats {R1,R0} and {R3,R2}, credits=30; memop_sync_end -> st_done one cycle later.
REQ-043 nregs=3 -> beats {R1,R0} then {0,R2}; nregs=0 -> straight to SYNC, no store_valid, st_done after memop_sync_end.
REQ-044 Credits drained to 0, then nregs=8 -> no store_valid, vs_ready low after 8 accepts (buffer full); one store_credit -> exactly one beat follows.
REQ-045 store_credit coinciding with a beat send -> credit count unchanged; 33 returns with no sends from reset -> count stays 32.
REQ-046 st_abort after 3 of 6 registers -> IDLE next cycle, busy=0, no st_done; new st_start with nregs=2 -> a single beat {R1,R0} of new data only.
REQ-047 reset_n low during XFER with buffer holding 5 entries -> all outputs 0 and credits=32 on the next cycle.
